// File: rtl/uart_boot_loader_if.sv
// Bus between the serial bootloader and the memory/processor side.
// Carries the rx line, the memory write port and the load status.
interface uart_boot_loader_if;
    logic        rx;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        input  rx,
        output mem_wr,
        output mem_addr,
        output mem_data,
        output cpu_hold,
        output done,
        output err
    );

    modport slave (
        output rx,
        input  mem_wr,
        input  mem_addr,
        input  mem_data,
        input  cpu_hold,
        input  done,
        input  err
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Serial bootloader: receives a framed image over 8N1 UART and writes
// it word by word into main memory from address 0, holding the CPU.
module uart_boot_loader #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int MAX_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    uart_boot_loader_if.master bus
);
    localparam int          DIV      = CLK_FREQ / (BAUD * 16);
    localparam int          DIVM1    = (DIV > 1) ? DIV - 1 : 0;
    localparam logic [15:0] DIV_LAST = 16'(DIVM1);
    localparam logic [16:0] MAXW     = 17'(MAX_WORDS);

    typedef enum logic [1:0] {
        R_HUNT, R_START, R_DATA, R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    logic [1:0]  sync_q;
    logic        rx_prev_q;
    logic        rx_s;

    rx_state_t   rs_q, rs_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  tcnt_q, tcnt_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        tick;
    logic        byte_valid;
    logic        frame_err;

    state_t      st_q, st_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] words_q, words_d;
    logic [1:0]  bytec_q, bytec_d;
    logic [7:0]  sum_q, sum_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        hold_q, hold_d;

    assign rx_s = sync_q[1];
    assign tick = (div_q == DIV_LAST);

    // Two-flop rx synchronizer plus a delayed copy for falling-edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], bus.rx};
            rx_prev_q <= rx_s;
        end
    end

    // Receiver state and oversampling counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q   <= R_HUNT;
            div_q  <= '0;
            tcnt_q <= '0;
            bcnt_q <= '0;
            sh_q   <= '0;
        end else begin
            rs_q   <= rs_d;
            div_q  <= div_d;
            tcnt_q <= tcnt_d;
            bcnt_q <= bcnt_d;
            sh_q   <= sh_d;
        end
    end

    // Receiver next state: start check at tick 8, then every 16 ticks.
    always_comb begin
        rs_d       = rs_q;
        div_d      = div_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        sh_d       = sh_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (rs_q != R_HUNT) begin
            div_d = tick ? '0 : div_q + 16'd1;
            if (tick) tcnt_d = tcnt_q + 4'd1;
        end
        unique case (rs_q)
            R_HUNT: begin
                if (rx_prev_q && !rx_s) begin
                    rs_d   = R_START;
                    div_d  = '0;
                    tcnt_d = '0;
                end
            end
            R_START: begin
                if (tick && tcnt_q == 4'd7) begin
                    if (rx_s) begin
                        rs_d = R_HUNT;
                    end else begin
                        rs_d   = R_DATA;
                        tcnt_d = '0;
                        bcnt_d = '0;
                    end
                end
            end
            R_DATA: begin
                if (tick && tcnt_q == 4'd15) begin
                    sh_d   = {rx_s, sh_q[7:1]};
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) rs_d = R_STOP;
                end
            end
            R_STOP: begin
                if (tick && tcnt_q == 4'd15) begin
                    rs_d = R_HUNT;
                    if (rx_s) byte_valid = 1'b1;
                    else      frame_err  = 1'b1;
                end
            end
            default: rs_d = R_HUNT;
        endcase
    end

    // Loader state and registered memory/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= S_IDLE;
            cnt_q   <= '0;
            words_q <= '0;
            bytec_q <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            bytec_q <= bytec_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    // Loader next state; DATA is left only after the last strobe clears.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        bytec_d = bytec_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        err_d   = err_q;
        done_d  = done_q;
        hold_d  = hold_q;
        unique case (st_q)
            S_IDLE: begin
                if (byte_valid && sh_q == 8'hA5) begin
                    st_d  = S_CNT_HI;
                    err_d = 1'b0;
                end
            end
            S_CNT_HI: begin
                if (byte_valid) begin
                    cnt_d = {sh_q, cnt_q[7:0]};
                    st_d  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (byte_valid) begin
                    cnt_d   = {cnt_q[15:8], sh_q};
                    sum_d   = '0;
                    addr_d  = '0;
                    words_d = '0;
                    bytec_d = '0;
                    if ({1'b0, cnt_q[15:8], sh_q} > MAXW)
                        st_d = S_ERR;
                    else if ({cnt_q[15:8], sh_q} == 16'd0)
                        st_d = S_CHK;
                    else
                        st_d = S_DATA;
                end
            end
            S_DATA: begin
                if (byte_valid) begin
                    data_d  = {data_q[23:0], sh_q};
                    sum_d   = sum_q + sh_q;
                    bytec_d = bytec_q + 2'd1;
                    if (bytec_q == 2'd3) begin
                        wr_d    = 1'b1;
                        words_d = words_q + 16'd1;
                    end
                end
                if (wr_q) begin
                    if (words_q == cnt_q) st_d = S_CHK;
                    else addr_d = addr_q + 32'd4;
                end
            end
            S_CHK: begin
                if (byte_valid)
                    st_d = (sh_q == sum_q) ? S_DONE : S_ERR;
            end
            S_DONE: st_d = S_DONE;
            S_ERR:  st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
        if (frame_err && st_q != S_IDLE && st_q != S_DONE)
            st_d = S_ERR;
        if (st_d == S_ERR) err_d = 1'b1;
        if (st_d == S_DONE) begin
            done_d = 1'b1;
            hold_d = 1'b0;
        end
    end

    assign bus.mem_wr   = wr_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign bus.cpu_hold = hold_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: serial images in, memory strobes and
// status checked against a word-list model of the expected load.
module tb_uart_boot_loader;
    localparam int CLK_FREQ = 320000;
    localparam int BAUD     = 10000;
    localparam int BIT      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_boot_loader_if bus();

    uart_boot_loader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .MAX_WORDS(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    logic [63:0] wq[$];
    logic [7:0]  img[$];
    logic [31:0] words[$];

    // Record every write strobe as {addr, data}.
    always @(negedge clk)
        if (bus.mem_wr === 1'b1) wq.push_back({bus.mem_addr, bus.mem_data});

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        bus.rx = stop;
        repeat (BIT) @(negedge clk);
        bus.rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i < to; i++) send_byte(img[i], 1'b1);
    endtask

    // Image built from the word list: header, count, bytes MSB first, sum.
    task automatic make_img(input logic bad);
        logic [7:0] s;
        logic [7:0] b;
        logic [15:0] n;
        img.delete();
        n = 16'(words.size());
        s = 8'd0;
        img.push_back(8'hA5);
        img.push_back(n[15:8]);
        img.push_back(n[7:0]);
        foreach (words[i])
            for (int k = 3; k >= 0; k--) begin
                b = words[i][k*8 +: 8];
                img.push_back(b);
                s = s + b;
            end
        img.push_back(s + {7'd0, bad});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        wq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.mem_wr, bus.cpu_hold, bus.done, bus.err} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_flags got %b want 0100",
                {bus.mem_wr, bus.cpu_hold, bus.done, bus.err});
        end
        tests++;
        if ({bus.mem_addr, bus.mem_data} !== 64'd0) begin
            fails++;
            $display("FAIL reset_bus got %h want 0", {bus.mem_addr, bus.mem_data});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load();
        do_reset();
        words = '{32'h11223344, 32'hAABBCCDD};
        make_img(1'b0);
        send_range(0, img.size());
        tests++;
        if (wq.size() != 2) begin
            fails++;
            $display("FAIL load_count got %0d want 2", wq.size());
        end
        foreach (words[i]) begin
            tests++;
            if (i >= wq.size() || wq[i] !== {32'(4 * i), words[i]}) begin
                fails++;
                $display("FAIL load_write%0d got %h want %h", i,
                    (i < wq.size()) ? wq[i] : 64'hx, {32'(4 * i), words[i]});
            end
        end
        tests++;
        if ({bus.done, bus.cpu_hold, bus.err} !== 3'b100) begin
            fails++;
            $display("FAIL load_status got %b want 100",
                {bus.done, bus.cpu_hold, bus.err});
        end
    endtask

    task automatic test_bad_sum();
        do_reset();
        words = '{32'h11223344, 32'hAABBCCDD};
        make_img(1'b1);
        send_range(0, img.size());
        tests++;
        if (wq.size() != 2) begin
            fails++;
            $display("FAIL badsum_count got %0d want 2", wq.size());
        end
        tests++;
        if ({bus.done, bus.cpu_hold, bus.err} !== 3'b011) begin
            fails++;
            $display("FAIL badsum_status got %b want 011",
                {bus.done, bus.cpu_hold, bus.err});
        end
        wq.delete();
        make_img(1'b0);
        send_range(0, img.size());
        tests++;
        if (wq.size() != 2 || wq[0] !== {32'd0, words[0]}) begin
            fails++;
            $display("FAIL resend_writes got %0d strobes want 2 from addr 0", wq.size());
        end
        tests++;
        if ({bus.done, bus.cpu_hold, bus.err} !== 3'b100) begin
            fails++;
            $display("FAIL resend_status got %b want 100",
                {bus.done, bus.cpu_hold, bus.err});
        end
    endtask

    task automatic test_garbage();
        do_reset();
        words = '{32'h11223344, 32'hAABBCCDD};
        make_img(1'b0);
        img.push_front(8'h5A);
        img.push_front(8'hFF);
        img.push_front(8'h00);
        send_range(0, img.size());
        tests++;
        if (wq.size() != 2) begin
            fails++;
            $display("FAIL garbage_count got %0d want 2", wq.size());
        end
        tests++;
        if (bus.done !== 1'b1) begin
            fails++;
            $display("FAIL garbage_done got %b want 1", bus.done);
        end
    endtask

    task automatic test_framing();
        do_reset();
        words = '{32'h11223344, 32'hAABBCCDD};
        make_img(1'b0);
        send_range(0, 4);
        send_byte(img[4], 1'b0);
        tests++;
        if ({bus.err, bus.done, bus.cpu_hold} !== 3'b101 || wq.size() != 0) begin
            fails++;
            $display("FAIL framing_err got err/done/hold %b strobes %0d want 101 and 0",
                {bus.err, bus.done, bus.cpu_hold}, wq.size());
        end
        send_range(0, img.size());
        tests++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0 || wq.size() != 2) begin
            fails++;
            $display("FAIL framing_recover got done %b err %b strobes %0d want 1 0 2",
                bus.done, bus.err, wq.size());
        end
        do_reset();
        send_range(0, 1);
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        send_range(1, img.size());
        tests++;
        if (bus.done !== 1'b1 || wq.size() != 2) begin
            fails++;
            $display("FAIL glitch got done %b strobes %0d want 1 and 2",
                bus.done, wq.size());
        end
    endtask

    task automatic test_bounds();
        do_reset();
        img = '{8'hA5, 8'h04, 8'h01};
        send_range(0, img.size());
        tests++;
        if ({bus.err, bus.done} !== 2'b10 || wq.size() != 0) begin
            fails++;
            $display("FAIL bounds_big got err/done %b strobes %0d want 10 and 0",
                {bus.err, bus.done}, wq.size());
        end
        do_reset();
        words.delete();
        make_img(1'b0);
        send_range(0, img.size());
        tests++;
        if ({bus.done, bus.cpu_hold, bus.err} !== 3'b100 || wq.size() != 0) begin
            fails++;
            $display("FAIL bounds_zero got %b strobes %0d want 100 and 0",
                {bus.done, bus.cpu_hold, bus.err}, wq.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        words = '{32'h01020304, 32'hA0B0C0D0};
        make_img(1'b0);
        send_range(0, 8);
        tests++;
        if (wq.size() != 1 || bus.mem_addr !== 32'd4) begin
            fails++;
            $display("FAIL midload_pre got strobes %0d addr %h want 1 and 4",
                wq.size(), bus.mem_addr);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus.mem_wr, bus.cpu_hold, bus.done, bus.err, bus.mem_addr, bus.mem_data}
            !== {4'b0100, 64'd0}) begin
            fails++;
            $display("FAIL midload_async got addr %h data %h hold %b want 0 0 1",
                bus.mem_addr, bus.mem_data, bus.cpu_hold);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        wq.delete();
        send_range(0, img.size());
        tests++;
        if (wq.size() != 2 || wq[0] !== {32'd0, words[0]} || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL midload_reload got strobes %0d done %b want 2 and 1",
                wq.size(), bus.done);
        end
    endtask

    task automatic test_random();
        logic bad;
        int n;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            words.delete();
            n = $urandom_range(1, 2);
            for (int i = 0; i < n; i++) words.push_back($urandom);
            bad = 1'($urandom_range(0, 1));
            make_img(bad);
            send_range(0, img.size());
            tests++;
            if (wq.size() != n) begin
                fails++;
                $display("FAIL rand%0d_count got %0d want %0d", it, wq.size(), n);
            end
            foreach (words[i]) begin
                tests++;
                if (i >= wq.size() || wq[i] !== {32'(4 * i), words[i]}) begin
                    fails++;
                    $display("FAIL rand%0d_write%0d got %h want %h", it, i,
                        (i < wq.size()) ? wq[i] : 64'hx, {32'(4 * i), words[i]});
                end
            end
            tests++;
            if ({bus.done, bus.cpu_hold, bus.err} !== (bad ? 3'b011 : 3'b100)) begin
                fails++;
                $display("FAIL rand%0d_status got %b want %b", it,
                    {bus.done, bus.cpu_hold, bus.err}, bad ? 3'b011 : 3'b100);
            end
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_load();
        test_bad_sum();
        test_garbage();
        test_framing();
        test_bounds();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
